// File: rtl/clock_enable_unit_pkg.sv
// Shared types and helpers for clock_enable_unit: FSM encoding, default field
// width and the effective divisor/phase computation used by every channel.
package clock_enable_unit_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    RUN       = 2'd2
  } ceu_state_t;

  localparam int DIV_WIDTH_DEF = 8;

  // Helper works at a fixed wide width; callers zero-extend in and truncate out.
  localparam int DIV_W_MAX = 32;

  typedef struct packed {
    logic [DIV_W_MAX-1:0] de;
    logic [DIV_W_MAX-1:0] pe;
  } div_phase_t;

  // De = max(d,1); Pe = p clamped into [0, De-1].
  function automatic div_phase_t eff_div_phase(input logic [DIV_W_MAX-1:0] d,
                                               input logic [DIV_W_MAX-1:0] p);
    div_phase_t r;
    r.de = (d == '0) ? DIV_W_MAX'(1) : d;
    r.pe = (p < r.de) ? p : (r.de - DIV_W_MAX'(1));
    return r;
  endfunction

endpackage

// File: rtl/clock_enable_unit_channel.sv
// One clock-enable channel: period counter, shadowed divisor/phase and the
// registered single-cycle strobe.
module clock_enable_channel
  import clock_enable_unit_pkg::*;
#(
  parameter int DIV_WIDTH = DIV_WIDTH_DEF
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_run,
  input  logic                 i_lock,
  input  logic                 i_enable,
  input  logic [DIV_WIDTH-1:0] i_div,
  input  logic [DIV_WIDTH-1:0] i_phase,
  output logic                 o_tick
);

  logic [DIV_WIDTH-1:0] r_cnt;
  logic [DIV_WIDTH-1:0] r_d_q;
  logic [DIV_WIDTH-1:0] r_p_q;
  logic                 r_tick;

  div_phase_t           w_eff;
  logic [DIV_WIDTH-1:0] w_de;
  logic [DIV_WIDTH-1:0] w_pe;
  logic [DIV_WIDTH-1:0] w_last;
  logic                 w_wrap;

  assign w_eff  = eff_div_phase(DIV_W_MAX'(r_d_q), DIV_W_MAX'(r_p_q));
  assign w_de   = DIV_WIDTH'(w_eff.de);
  assign w_pe   = DIV_WIDTH'(w_eff.pe);
  assign w_last = w_de - DIV_WIDTH'(1);
  assign w_wrap = (r_cnt == w_last);

  // Shadows only reload at the period boundary while running, so a new
  // divisor or phase never truncates or doubles a period.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_cnt  <= '0;
      r_d_q  <= '0;
      r_p_q  <= '0;
      r_tick <= 1'b0;
    end else begin
      if (i_run) begin
        r_cnt <= w_wrap ? '0 : (r_cnt + DIV_WIDTH'(1));
        if (w_wrap) begin
          r_d_q <= i_div;
          r_p_q <= i_phase;
        end
      end else begin
        r_cnt <= '0;
        r_d_q <= i_div;
        r_p_q <= i_phase;
      end
      r_tick <= i_run && i_lock && i_enable && (r_cnt == w_pe);
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/clock_enable_unit.sv
// Multi-channel clock-enable generator gated by PLL lock and a settle period.
// Optional lock synchronizer: define CLOCK_ENABLE_UNIT_LOCK_SYNC_EN.
module clock_enable_unit
  import clock_enable_unit_pkg::*;
#(
  parameter int NUM_CHANNELS  = 3,
  parameter int DIV_WIDTH     = DIV_WIDTH_DEF,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                              i_clock,
  input  logic                              i_reset,
  input  logic                              i_locked,
  input  logic [NUM_CHANNELS-1:0]           i_enable,
  input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] i_div,
  input  logic [NUM_CHANNELS*DIV_WIDTH-1:0] i_phase,
  output logic [NUM_CHANNELS-1:0]           o_tick,
  output logic                              o_valid
);

  localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);

  ceu_state_t          r_state;
  ceu_state_t          w_state_nxt;
  logic [SETTLE_W-1:0] r_settle;
  logic [SETTLE_W-1:0] w_settle_nxt;
  logic                w_lock_s;
  logic                w_run;

`ifdef CLOCK_ENABLE_UNIT_LOCK_SYNC_EN
  logic [1:0] r_lock_sync;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_lock_sync <= 2'b00;
    end else begin
      r_lock_sync <= {r_lock_sync[0], i_locked};
    end
  end

  assign w_lock_s = r_lock_sync[1];
`else
  assign w_lock_s = i_locked;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state  <= WAIT_LOCK;
      r_settle <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_settle <= w_settle_nxt;
    end
  end

  // Settle counter only advances while lock holds in SETTLE; any exit clears it.
  always_comb begin
    w_state_nxt  = r_state;
    w_settle_nxt = '0;
    unique case (r_state)
      WAIT_LOCK: begin
        if (w_lock_s) w_state_nxt = SETTLE;
      end
      SETTLE: begin
        if (!w_lock_s) begin
          w_state_nxt = WAIT_LOCK;
        end else if (r_settle == SETTLE_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_settle_nxt = r_settle + SETTLE_W'(1);
        end
      end
      RUN: begin
        if (!w_lock_s) w_state_nxt = WAIT_LOCK;
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  assign w_run   = (r_state == RUN);
  assign o_valid = w_run;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    clock_enable_channel #(
      .DIV_WIDTH (DIV_WIDTH)
    ) u_ch (
      .i_clock  (i_clock),
      .i_reset  (i_reset),
      .i_run    (w_run),
      .i_lock   (w_lock_s),
      .i_enable (i_enable[c]),
      .i_div    (i_div[c*DIV_WIDTH +: DIV_WIDTH]),
      .i_phase  (i_phase[c*DIV_WIDTH +: DIV_WIDTH]),
      .o_tick   (o_tick[c])
    );
  end

endmodule

// File: tb/tb_clock_enable_unit.sv
// Directed bench for clock_enable_unit: lock/settle, strobe grids, lock loss,
// degenerate settings, enable masking, divisor change and async reset.
module tb_clock_enable_unit;

`ifdef CLOCK_ENABLE_UNIT_LOCK_SYNC_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif
  localparam int SETTLE = 16;
  localparam int L  = S + SETTLE + 1;
  localparam int T1 = 10 + L;
  localparam int T2 = 51 + L;
  localparam int EM = T2 + 5;
  localparam int KC = T2 + 21;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_locked;
  logic [2:0]  i_enable;
  logic [23:0] i_div;
  logic [23:0] i_phase;
  logic [2:0]  o_tick;
  logic        o_valid;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  clock_enable_unit #(
    .NUM_CHANNELS  (3),
    .DIV_WIDTH     (8),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .i_clock  (i_clock),
    .i_reset  (i_reset),
    .i_locked (i_locked),
    .i_enable (i_enable),
    .i_div    (i_div),
    .i_phase  (i_phase),
    .o_tick   (o_tick),
    .o_valid  (o_valid)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge i_clock);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Strobe grid: first tick at t+1+pe, then every de cycles.
  function automatic logic pat(input int k, input int t, input int de, input int pe);
    if (k < t + 1 + pe) return 1'b0;
    return ((k - t - 1 - pe) % de) == 0;
  endfunction

  initial begin
    logic       ev;
    logic [2:0] et;
    int         r0;

    i_reset  = 1'b0;
    i_locked = 1'b0;
    i_enable = 3'b111;
    i_div    = {8'd1, 8'd3, 8'd4};
    i_phase  = {8'd0, 8'd2, 8'd0};
    repeat (3) @(posedge i_clock);
    #1;
    chk("reset_valid", o_valid, 1'b0);
    chk("reset_tick", o_tick, 3'b000);
    i_reset = 1'b1;
    cyc = 0;

    // Lock at cycle 10, basic strobe grid.
    for (int k = 1; k <= 45; k++) begin
      step();
      if (cyc == 10) i_locked = 1'b1;
      ev = (cyc >= T1);
      et = {pat(cyc, T1, 1, 0), pat(cyc, T1, 3, 2), pat(cyc, T1, 4, 0)};
      chk("basic_valid", ev, o_valid);
      chk("basic_tick", o_tick, et);
    end

    // Lock dropout, degenerate settings on relock, enable mask, divisor change.
    for (int k = 46; k <= T2 + 45; k++) begin
      step();
      if (cyc == 46) begin
        i_locked = 1'b0;
        i_div    = {8'd0, 8'd3, 8'd4};
        i_phase  = {8'd0, 8'd7, 8'd0};
      end
      if (cyc == 51)      i_locked = 1'b1;
      if (cyc == EM)      i_enable = 3'b101;
      if (cyc == EM + 10) i_enable = 3'b111;
      if (cyc == KC)      i_div[7:0] = 8'd6;
      ev = ((cyc >= T1) && (cyc < 47 + S)) || (cyc >= T2);
      if (cyc <= 46 + S) begin
        et = {pat(cyc, T1, 1, 0), pat(cyc, T1, 3, 2), pat(cyc, T1, 4, 0)};
      end else if (cyc < T2) begin
        et = 3'b000;
      end else begin
        et[2] = pat(cyc, T2, 1, 0);
        et[1] = pat(cyc, T2, 3, 2) && !((cyc - 1 >= EM) && (cyc - 1 <= EM + 9));
        if (cyc <= T2 + 25) et[0] = pat(cyc, T2, 4, 0);
        else                et[0] = ((cyc - T2 - 25) % 6) == 0;
      end
      chk("run2_valid", o_valid, ev);
      chk("run2_tick", o_tick, et);
    end

    // Asynchronous reset in the middle of a cycle.
    chk("pre_reset_tick2", o_tick[2], 1'b1);
    #2;
    i_reset = 1'b0;
    #1;
    chk("async_rst_valid", o_valid, 1'b0);
    chk("async_rst_tick", o_tick, 3'b000);
    step();
    step();
    chk("held_rst_valid", o_valid, 1'b0);
    chk("held_rst_tick", o_tick, 3'b000);
    i_reset = 1'b1;
    r0 = cyc;
    for (int k = 1; k <= L + 8; k++) begin
      step();
      ev = (cyc >= r0 + L);
      et = {pat(cyc, r0 + L, 1, 0), pat(cyc, r0 + L, 3, 2), pat(cyc, r0 + L, 6, 0)};
      chk("recover_valid", o_valid, ev);
      chk("recover_tick", o_tick, et);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_enable_unit.md
# clock_enable_unit

Parametrised successor to the fixed three-output clock unit. It runs on one system clock and generates NUM_CHANNELS single-cycle clock-enable strobes, each with a runtime-programmable divide ratio and phase offset. The strobes are qualified by an upstream PLL lock indication and a settle period. Downstream logic stays on one clock and uses these strobes instead of extra clock nets.

## Interface
- NUM_CHANNELS, 3, number of independent enable channels (1..16)
- DIV_WIDTH, 8, width of per-channel divide and phase fields
- SETTLE_CYCLES, 16, cycles of stable lock required before o_valid asserts (≥1)
- i_clock  input  1  system clock; all logic on rising edge
- i_reset  input  1  asynchronous, active-low reset
- i_locked  input  1  PLL lock indication; may be asynchronous to i_clock
- i_enable  input  NUM_CHANNELS  per-channel strobe enable
- i_div  input  NUM_CHANNELS*DIV_WIDTH  per-channel divisor D; channel c occupies bits [c*DIV_WIDTH +: DIV_WIDTH]
- i_phase  input  NUM_CHANNELS*DIV_WIDTH  per-channel phase P, packed the same way
- o_tick  output  NUM_CHANNELS  per-channel strobe; high for exactly one cycle per period
- o_valid  output  1  high while in RUN

## Operation
- Control FSM, three states:
  - WAIT_LOCK: reset state. Moves to SETTLE when the lock signal (lock_s) is high.
  - SETTLE: a settle counter counts up from 0. Moves to RUN when the counter reaches SETTLE_CYCLES-1 with lock_s still high. Returns to WAIT_LOCK if lock_s drops.
  - RUN: stays in RUN while lock_s is high. Moves to WAIT_LOCK in the cycle after lock_s falls.
- Lock signal: lock_s is i_locked after the optional synchronizer (see Configuration).
- o_valid is 1 exactly when the state is RUN.
- Each channel has a counter cnt of width DIV_WIDTH, plus shadow registers d_q and p_q.
- Effective divisor: De = max(d_q, 1).
- Effective phase: Pe = p_q if p_q < De, otherwise De-1 (clamped).
- Counter behaviour in RUN: cnt increments each cycle and wraps from De-1 to 0. With De=1, cnt stays at 0.
- Counter and shadow registers outside RUN:
  - cnt is held at 0.
  - d_q and p_q load from i_div and i_phase every cycle.
- Shadow update in RUN: d_q and p_q reload only in the wrap cycle, i.e. the cycle where cnt == De-1. A divisor or phase change therefore takes effect at a period boundary and never produces a truncated or doubled strobe.
- Tick condition: o_tick[c] is a register set to (state==RUN && lock_s && i_enable[c] && cnt==Pe).
- i_enable has no effect on cnt; deasserting it only masks ticks, so phase alignment between channels is preserved.

## Timing
- Reset values: state=WAIT_LOCK, o_valid=0, o_tick=0, all cnt=0, settle counter=0, synchronizer flops=0, d_q=0, p_q=0.
- Lock to valid: with the synchronizer compiled in, i_locked rises → o_valid rises 2+SETTLE_CYCLES+1 cycles later.
- RUN entry: define cycle T as the first cycle with o_valid=1. At T, cnt=0 in every channel.
- First strobe: first o_tick[c] is at T+1+Pe. After that, strobes repeat every De cycles.
- Tick latency: 1 cycle from the cnt==Pe match to o_tick.
- Loss of lock: o_tick is forced to 0 starting the cycle after lock_s falls. o_valid falls in that same cycle.
- Simultaneous wrap and new i_div: the new value is used starting with cnt=0 of the next period.
- Lock drop during SETTLE: the settle counter clears and the full settle period restarts on relock.
- Reset mid-operation: all outputs go to reset values immediately (asynchronous). Recovery follows the lock-to-valid path.

## Configuration
- Macro: CLOCK_ENABLE_UNIT_LOCK_SYNC_EN.
- Defined: i_locked passes through a 2-flop synchronizer to produce lock_s (2 cycles of latency).
- Undefined: lock_s = i_locked directly. The integrator guarantees i_locked is synchronous to i_clock. Lock-to-valid latency becomes SETTLE_CYCLES+1.

## Structure
- Package clock_enable_unit_pkg contains:
  - the FSM state encoding: WAIT_LOCK=2'd0, SETTLE=2'd1, RUN=2'd2
  - the DIV_WIDTH default
  - a function computing De and Pe from raw d and p values
- Sub-module clock_enable_channel holds one channel's cnt, d_q, p_q and tick register. It is instantiated NUM_CHANNELS times in a generate loop and receives run/enable qualifiers from the top-level FSM.

## Test plan
- Basic strobes: default params, sync enabled; i_locked rises at cycle 10, div={4,3,1}, phase={0,2,0}, all enabled → o_valid at cycle 29; ch0 ticks 30,34,38; ch1 ticks 32,35,38; ch2 ticks every cycle from 30.
- Lock dropout: in RUN, drop i_locked for 5 cycles → o_valid and o_tick go low in the cycle after lock_s falls; after relock, o_valid returns after the full settle period with all cnt restarted at 0.
- Divisor change mid-period: ch0 div changes 4→6 while cnt=1 → the remaining ticks of the current period keep a spacing of 4; the next spacing is 6; no extra or missing strobe.
- Degenerate settings: div=0 with phase=0 → tick every cycle; div=3 with phase=7 → ticks at cnt=2 (clamped).
- Enable masking: i_enable[1]=0 for 10 cycles, then 1 → no ch1 ticks during the mask; after re-enable, ticks land on the original phase grid.
- Reset during RUN: assert i_reset mid-period → o_tick=0 and o_valid=0 asynchronously; after release with i_locked=1, o_valid rises 19 cycles later.
